// File: rtl/sensor_pkg.sv
// rtl/sensor_pkg.sv - shared types and default parameters for the sensor monitor
package sensor_pkg;

    typedef enum logic [1:0] {
        MON_IDLE    = 2'd0,
        MON_ALARM   = 2'd1,
        MON_HOLDOFF = 2'd2
    } mon_state_t;

    localparam int SENS_DEBOUNCE = 4;
    localparam int SENS_HOLDOFF  = 8;
    localparam int SENS_CNT_W    = 8;

endpackage

// File: rtl/sensor_monitor_if.sv
// rtl/sensor_monitor_if.sv - sensor/host signal bundle for the sensor monitor
// Z, CLR, ACK : driven by the sensor/host side (master)
// LEVEL, EVENT, COUNT, ALARM : driven by the monitor (slave)
interface sensor_monitor_if
    import sensor_pkg::*;
#(
    parameter int CNT_W = SENS_CNT_W
);
    logic             Z;
    logic             CLR;
    logic             ACK;
    logic             LEVEL;
    logic             EVENT;
    logic [CNT_W-1:0] COUNT;
    logic             ALARM;

    modport master (output Z, CLR, ACK, input LEVEL, EVENT, COUNT, ALARM);
    modport slave  (input Z, CLR, ACK, output LEVEL, EVENT, COUNT, ALARM);
endinterface

// File: rtl/sensor_debounce.sv
// rtl/sensor_debounce.sv - samples Z and debounces it into LEVEL with a rise pulse
// CLK, MR (async active-low) : clock and reset
// Z          : raw sensor output
// LEVEL      : debounced level
// RISE       : registered one-cycle pulse aligned with LEVEL 0->1
// rise_next  : value RISE takes at the coming edge (lets the top update on the same edge)
module sensor_debounce
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE = SENS_DEBOUNCE
) (
    input  logic CLK,
    input  logic MR,
    input  logic Z,
    output logic LEVEL,
    output logic RISE,
    output logic rise_next
);
    localparam int CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          zq_q, zq_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          rise_q, rise_d;

    always_comb begin
        zq_d    = Z;
        cnt_d   = cnt_q;
        level_d = level_q;
        if (zq_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == LAST) begin
            level_d = zq_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
        rise_d = level_d & ~level_q;
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            zq_q    <= 1'b0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
        end else begin
            zq_q    <= zq_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
        end
    end

    assign LEVEL     = level_q;
    assign RISE      = rise_q;
    assign rise_next = rise_d;
endmodule

// File: rtl/sensor_monitor.sv
// rtl/sensor_monitor.sv - debounced event counter with latched, acknowledged alarm
// CLK, MR (async active-low) : clock and reset
// bus (slave) : Z, CLR, ACK in; LEVEL, EVENT, COUNT, ALARM out
module sensor_monitor
    import sensor_pkg::*;
#(
    parameter int DEBOUNCE = SENS_DEBOUNCE,
    parameter int HOLDOFF  = SENS_HOLDOFF,
    parameter int CNT_W    = SENS_CNT_W
) (
    input  logic             CLK,
    input  logic             MR,
    sensor_monitor_if.slave  bus
);
    localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);

    logic level, rise, rise_next;

    mon_state_t       state_q, state_d;
    logic             alarm_q, alarm_d;
    logic [HW-1:0]    hold_q, hold_d;
    logic [CNT_W-1:0] count_q, count_d;

    sensor_debounce #(.DEBOUNCE(DEBOUNCE)) u_debounce (
        .CLK       (CLK),
        .MR        (MR),
        .Z         (bus.Z),
        .LEVEL     (level),
        .RISE      (rise),
        .rise_next (rise_next)
    );

    // Clear wins over a same-edge increment; the count sticks at all-ones.
    always_comb begin
        count_d = count_q;
        if (bus.CLR) begin
            count_d = '0;
        end else if (rise_next && (count_q != '1)) begin
            count_d = count_q + 1'b1;
        end
    end

    // Events only raise the alarm from MON_IDLE; the edge that leaves
    // MON_HOLDOFF is still holdoff, so an event there is ignored.
    always_comb begin
        state_d = state_q;
        alarm_d = alarm_q;
        hold_d  = hold_q;
        unique case (state_q)
            MON_IDLE: begin
                if (rise_next) begin
                    alarm_d = 1'b1;
                    state_d = MON_ALARM;
                end
            end
            MON_ALARM: begin
                if (bus.ACK) begin
                    alarm_d = 1'b0;
                    hold_d  = HOLD_LOAD;
                    state_d = MON_HOLDOFF;
                end
            end
            MON_HOLDOFF: begin
                if (hold_q == '0) begin
                    state_d = MON_IDLE;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: state_d = MON_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge MR) begin
        if (!MR) begin
            state_q <= MON_IDLE;
            alarm_q <= 1'b0;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            alarm_q <= alarm_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    assign bus.LEVEL = level;
    assign bus.EVENT = rise;
    assign bus.COUNT = count_q;
    assign bus.ALARM = alarm_q;
endmodule

// File: tb/tb_sensor_monitor.sv
// tb/tb_sensor_monitor.sv - self-checking bench for sensor_monitor
module tb_sensor_monitor;
    localparam int DEB  = 4;
    localparam int HOLD = 8;

    logic clk  = 1'b0;
    logic mr_n = 1'b0;

    int vectors    = 0;
    int miscompares = 0;

    sensor_monitor_if #(.CNT_W(8)) sif ();

    sensor_monitor #(.DEBOUNCE(DEB), .HOLDOFF(HOLD), .CNT_W(8)) dut (
        .CLK (clk),
        .MR  (mr_n),
        .bus (sif)
    );

    always #5 clk = ~clk;

    // Reference model: LEVEL follows zq once zq has disagreed with it for
    // DEB consecutive samples; the alarm is raised by an accepted rise unless
    // it is already up or the edge falls inside the HOLD edges after an ack.
    logic       m_zq = 1'b0, m_level = 1'b0, m_event = 1'b0, m_alarm = 1'b0;
    logic [7:0] m_count = 8'd0;
    int         m_run = 0, m_cyc = 0, m_quiet = -1;

    task automatic model_reset();
        m_zq = 1'b0; m_level = 1'b0; m_event = 1'b0; m_alarm = 1'b0;
        m_count = 8'd0; m_run = 0; m_cyc = 0; m_quiet = -1;
    endtask

    task automatic model_step();
        logic rise;
        rise = 1'b0;
        if (m_zq != m_level) begin
            m_run++;
            if (m_run >= DEB) begin
                m_level = m_zq;
                m_run   = 0;
                rise    = m_level;
            end
        end else begin
            m_run = 0;
        end
        m_event = rise;
        if (sif.CLR) m_count = 8'd0;
        else if (rise && m_count != 8'hFF) m_count = m_count + 8'd1;
        m_cyc++;
        if (m_alarm && sif.ACK) begin
            m_alarm = 1'b0;
            m_quiet = m_cyc + HOLD;
        end else if (!m_alarm && rise && m_cyc > m_quiet) begin
            m_alarm = 1'b1;
        end
        m_zq = sif.Z;
    endtask

    always @(posedge clk or negedge mr_n) begin
        if (!mr_n) model_reset();
        else       model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        mr_n = 1'b0; sif.Z = 1'b0; sif.CLR = 1'b0; sif.ACK = 1'b0;
        repeat (3) tick();
        vectors++;
        if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_held: got %b/%b/%0d/%b want 0/0/0/0", sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
        end
        mr_n = 1'b1;
        repeat (2) tick();
        vectors++;
        if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== 11'd0) begin
            miscompares++;
            $display("FAIL reset_release: got %b/%b/%0d/%b want 0/0/0/0", sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
        end
    endtask

    task automatic test_glitch();
        sif.Z = 1'b1;
        repeat (3) tick();
        sif.Z = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            vectors++;
            if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== 11'd0) begin
                miscompares++;
                $display("FAIL glitch cyc %0d: got %b/%b/%0d/%b want 0/0/0/0", i, sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
            end
        end
    endtask

    task automatic test_rising();
        sif.Z = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 3) begin
                vectors++;
                if (sif.LEVEL !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rise_early: LEVEL got %b want 0 at edge 3", sif.LEVEL);
                end
            end
        end
        vectors++;
        if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== {1'b1, 1'b1, 8'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL rise_edge4: got %b/%b/%0d/%b want 1/1/1/1", sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
        end
        tick();
        vectors++;
        if ({sif.EVENT, sif.COUNT} !== {1'b0, 8'd1}) begin
            miscompares++;
            $display("FAIL rise_pulse_width: EVENT/COUNT got %b/%0d want 0/1", sif.EVENT, sif.COUNT);
        end
    endtask

    task automatic test_falling();
        sif.Z = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            vectors++;
            if (sif.EVENT !== 1'b0) begin
                miscompares++;
                $display("FAIL fall_event cyc %0d: EVENT got %b want 0", i, sif.EVENT);
            end
        end
        vectors++;
        if ({sif.LEVEL, sif.COUNT, sif.ALARM} !== {1'b0, 8'd1, 1'b1}) begin
            miscompares++;
            $display("FAIL fall_edge4: LEVEL/COUNT/ALARM got %b/%0d/%b want 0/1/1", sif.LEVEL, sif.COUNT, sif.ALARM);
        end
    endtask

    task automatic test_ack_holdoff();
        // rise completing on holdoff edge 3
        sif.Z = 1'b1;
        tick();
        sif.ACK = 1'b1;
        tick();
        sif.ACK = 1'b0;
        vectors++;
        if (sif.ALARM !== 1'b0) begin
            miscompares++;
            $display("FAIL ack_clear: ALARM got %b want 0", sif.ALARM);
        end
        repeat (3) tick();
        vectors++;
        if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== {1'b1, 1'b1, 8'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL holdoff_event: got %b/%b/%0d/%b want 1/1/2/0", sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
        end
        sif.Z = 1'b0;
        repeat (9) tick();
        sif.Z = 1'b1;
        repeat (5) tick();
        vectors++;
        if ({sif.EVENT, sif.COUNT, sif.ALARM} !== {1'b1, 8'd3, 1'b1}) begin
            miscompares++;
            $display("FAIL idle_event: EVENT/COUNT/ALARM got %b/%0d/%b want 1/3/1", sif.EVENT, sif.COUNT, sif.ALARM);
        end
        sif.Z = 1'b0;
        repeat (6) tick();
        // rise completing on the edge that leaves holdoff (ACK edge + 8)
        sif.ACK = 1'b1;
        tick();
        sif.ACK = 1'b0;
        repeat (3) tick();
        sif.Z = 1'b1;
        repeat (5) tick();
        vectors++;
        if ({sif.EVENT, sif.COUNT, sif.ALARM} !== {1'b1, 8'd4, 1'b0}) begin
            miscompares++;
            $display("FAIL holdoff_exit_event: EVENT/COUNT/ALARM got %b/%0d/%b want 1/4/0", sif.EVENT, sif.COUNT, sif.ALARM);
        end
        sif.Z = 1'b0;
        repeat (6) tick();
        sif.Z = 1'b1;
        repeat (5) tick();
        sif.Z = 1'b0;
        repeat (6) tick();
        // rise completing 9 cycles after ACK, first idle cycle
        sif.ACK = 1'b1;
        tick();
        sif.ACK = 1'b0;
        repeat (4) tick();
        sif.Z = 1'b1;
        repeat (5) tick();
        vectors++;
        if ({sif.EVENT, sif.COUNT, sif.ALARM} !== {1'b1, 8'd6, 1'b1}) begin
            miscompares++;
            $display("FAIL first_idle_event: EVENT/COUNT/ALARM got %b/%0d/%b want 1/6/1", sif.EVENT, sif.COUNT, sif.ALARM);
        end
        sif.Z = 1'b0;
        repeat (6) tick();
        vectors++;
        if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== {m_level, m_event, m_count, m_alarm}) begin
            miscompares++;
            $display("FAIL ack_model: got %b/%b/%0d/%b want %b/%b/%0d/%b", sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM, m_level, m_event, m_count, m_alarm);
        end
    endtask

    task automatic test_saturation_clear();
        for (int i = 0; i < 260; i++) begin
            sif.Z = 1'b1;
            repeat (5) tick();
            sif.Z = 1'b0;
            repeat (5) tick();
        end
        vectors++;
        if (sif.COUNT !== 8'd255) begin
            miscompares++;
            $display("FAIL saturate: COUNT got %0d want 255", sif.COUNT);
        end
        sif.Z = 1'b1;
        repeat (4) tick();
        sif.CLR = 1'b1;
        tick();
        sif.CLR = 1'b0;
        vectors++;
        if ({sif.EVENT, sif.COUNT} !== {1'b1, 8'd0}) begin
            miscompares++;
            $display("FAIL clr_vs_event: EVENT/COUNT got %b/%0d want 1/0", sif.EVENT, sif.COUNT);
        end
        tick();
        vectors++;
        if ({sif.EVENT, sif.COUNT} !== {1'b0, 8'd0}) begin
            miscompares++;
            $display("FAIL clr_after: EVENT/COUNT got %b/%0d want 0/0", sif.EVENT, sif.COUNT);
        end
        sif.Z = 1'b0;
        repeat (6) tick();
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 7; i++) begin
            sif.Z = 1'b1;
            repeat (5) tick();
            sif.Z = 1'b0;
            repeat (5) tick();
        end
        vectors++;
        if ({sif.COUNT, sif.ALARM} !== {8'd7, 1'b1}) begin
            miscompares++;
            $display("FAIL pre_reset: COUNT/ALARM got %0d/%b want 7/1", sif.COUNT, sif.ALARM);
        end
        sif.Z = 1'b1;
        repeat (2) tick();
        #2;
        mr_n = 1'b0;
        #1;
        vectors++;
        if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== 11'd0) begin
            miscompares++;
            $display("FAIL async_reset: got %b/%b/%0d/%b want 0/0/0/0", sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
        end
        sif.Z = 1'b0;
        tick();
        mr_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            vectors++;
            if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== 11'd0) begin
                miscompares++;
                $display("FAIL post_reset cyc %0d: got %b/%b/%0d/%b want 0/0/0/0", i, sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM);
            end
        end
    endtask

    task automatic test_random();
        int run_left;
        run_left = 0;
        for (int i = 0; i < 4000; i++) begin
            tick();
            vectors++;
            if ({sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM} !== {m_level, m_event, m_count, m_alarm}) begin
                miscompares++;
                $display("FAIL random cyc %0d: got %b/%b/%0d/%b want %b/%b/%0d/%b", i, sif.LEVEL, sif.EVENT, sif.COUNT, sif.ALARM, m_level, m_event, m_count, m_alarm);
            end
            if (run_left == 0) begin
                sif.Z    = 1'($urandom_range(0, 1));
                run_left = $urandom_range(1, 9);
            end
            run_left--;
            sif.ACK = ($urandom_range(0, 5) == 0);
            sif.CLR = ($urandom_range(0, 40) == 0);
            if ($urandom_range(0, 599) == 0) begin
                #2 mr_n = 1'b0;
                #1 mr_n = 1'b1;
            end
        end
        sif.ACK = 1'b0;
        sif.CLR = 1'b0;
    endtask

    initial begin
        sif.Z = 1'b0; sif.CLR = 1'b0; sif.ACK = 1'b0;
        test_reset();
        test_glitch();
        test_rising();
        test_falling();
        test_ack_holdoff();
        test_saturation_clear();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/sensor_monitor.md
# sensor_monitor

Consumer-side companion to the sensor state machine. It samples the sensor's `Z` output in the same `CLK` domain and debounces it into a clean level. It counts accepted rising events and raises a latched alarm that the host clears with an acknowledge and holdoff handshake. It sits between the sensor and the host/status logic and is the reader for everything the sensor produces.

## Interface
- `DEBOUNCE`, 4: consecutive cycles a sampled `Z` value must differ from `LEVEL` before `LEVEL` takes it (≥1).
- `HOLDOFF`, 8: cycles spent in holdoff after an acknowledge, during which no new alarm may be raised (≥1).
- `CNT_W`, 8: width of the event counter.

- `CLK` in 1: single clock, rising-edge.
- `MR` in 1: master reset, asynchronous, active-low.
- `Z` in 1: sensor output, synchronous to `CLK`.
- `CLR` in 1: synchronous clear of `COUNT`.
- `ACK` in 1: host acknowledge of `ALARM`.
- `LEVEL` out 1: debounced `Z`.
- `EVENT` out 1: one-cycle pulse on each accepted 0→1 of `LEVEL`.
- `COUNT` out `CNT_W`: saturating count of accepted events.
- `ALARM` out 1: latched alarm.

## Operation
- **Reset.** `MR`=0 asynchronously forces every register to zero: `zq`=0, debounce counter=0, `LEVEL`=0, `EVENT`=0, `COUNT`=0, `ALARM`=0, holdoff counter=0, state MON_IDLE.
- **Sampling.** `zq` <= `Z` every cycle.
- **Debounce.**
  - If `zq`==`LEVEL`, the debounce counter goes to 0.
  - Otherwise the counter increments.
  - When it reaches `DEBOUNCE`-1 while `zq`!=`LEVEL`, `LEVEL` <= `zq` and the counter goes to 0.
  - Glitches shorter than `DEBOUNCE` sampled cycles never reach `LEVEL`.
- **Event.**
  - On the edge where `LEVEL` goes 0→1: `EVENT`<=1 for exactly one cycle and `COUNT` <= `COUNT`+1.
  - `COUNT` saturates at all-ones.
  - A `LEVEL` 1→0 transition produces no `EVENT`.
- **CLR.** `COUNT`<=0. `CLR` has priority over a same-cycle increment; `EVENT` still pulses.
- **FSM.**
  - MON_IDLE: an event sets `ALARM`<=1 and moves to MON_ALARM.
  - MON_ALARM: `ALARM` is held. `ACK`=1 clears `ALARM`<=0, loads the holdoff counter with `HOLDOFF`-1, and moves to MON_HOLDOFF. Further events are counted but change nothing else.
  - MON_HOLDOFF: the counter decrements each cycle. At 0 the FSM goes to MON_IDLE. Events are counted; no alarm is raised.
- **Boundary rules.**
  - `ACK` in MON_IDLE or MON_HOLDOFF is ignored.
  - `ACK` on the same edge that sets `ALARM` is ignored, because the FSM is still in MON_IDLE.
  - An event on the edge that leaves MON_HOLDOFF belongs to holdoff and raises no alarm.
  - An event in the first MON_IDLE cycle after holdoff raises the alarm.
  - `MR` low mid-operation, including mid-debounce or mid-holdoff, discards all state immediately.
  - `MR` released: operation resumes at the first rising `CLK` edge after release.

## Timing
- **Latency.** With `Z` stepping 0→1 just before edge *t* and held: `zq`=1 after edge *t*; `LEVEL`, `EVENT`, `COUNT`+1 and `ALARM` (from MON_IDLE) all update at edge *t*+`DEBOUNCE`. For `DEBOUNCE`=4 that is 5 edges counting edge *t*.
- **Falling latency.** Identical for a 1→0 step of `LEVEL`.
- **Outputs.** All outputs are registered; none is combinational from inputs.
- **ALARM clear.** `ALARM` falls on the edge `ACK`=1 is sampled in MON_ALARM.
- **Holdoff length.** MON_HOLDOFF lasts exactly `HOLDOFF` cycles, then MON_IDLE.
- **Event spacing.** Minimum spacing between two `EVENT` pulses is 2·`DEBOUNCE` cycles.

## Structure
- **Package `sensor_pkg`.**
  - State enum `mon_state_t` {MON_IDLE, MON_ALARM, MON_HOLDOFF}.
  - Default constants `SENS_DEBOUNCE`=4, `SENS_HOLDOFF`=8, `SENS_CNT_W`=8.
- **Sub-module `sensor_debounce`.**
  - Ports: `CLK`, `MR`, `Z` in; `LEVEL`, `RISE` out.
  - Contains the `zq` register and the debounce counter.
  - `RISE` is a registered one-cycle pulse aligned with `LEVEL` 0→1.
- **Top level.** Holds the FSM, holdoff counter and `COUNT`; `EVENT` = `RISE`.

## Test plan
All scenarios use `DEBOUNCE`=4, `HOLDOFF`=8, `CNT_W`=8.

1. **Async reset.** Drive `MR` low between clock edges while `ALARM`=1 and `COUNT`=7 → all outputs 0 immediately, before the next edge. Release `MR`, then `Z`=0 for 10 cycles → outputs stay 0.
2. **Rising event.** `Z` 0→1 before edge 0, held → at edge 4: `LEVEL`=1, `EVENT`=1 for one cycle, `COUNT`=1, `ALARM`=1.
3. **Glitch rejection.** `Z`=1 for 3 cycles, then 0 → `LEVEL`, `EVENT`, `COUNT` and `ALARM` stay 0.
4. **Ack and holdoff.**
   - `ACK`=1 one cycle in MON_ALARM → `ALARM`=0 at that edge.
   - A debounced rise completing in holdoff cycle 3 → `COUNT`+1, `EVENT` pulse, `ALARM` stays 0.
   - A rise completing 9 cycles after `ACK` → `ALARM`=1.
5. **Saturation and clear.**
   - 260 spaced events → `COUNT`=255.
   - `CLR`=1 on the same edge as an `EVENT` → `COUNT`=0 and `EVENT`=1.
6. **Falling edge.** `Z` 1→0 held with `LEVEL`=1 → `LEVEL`=0 at edge 4; no `EVENT`; `COUNT` and `ALARM` unchanged.
